// File: rtl/alarm_ctrl.sv
// Alarm controller: stores a BCD alarm time, rings on the rising edge of a time match,
// supports stop/arm/snooze buttons and a ring timeout. Snooze exists only with ALARM_SNOOZE_EN.
module alarm_ctrl #(
   parameter int unsigned SNOOZE_MIN       = 5,
   parameter int unsigned RING_TIMEOUT_SEC = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   input  logic [3:0] hourdec_set,
   input  logic [3:0] hourone_set,
   input  logic [3:0] mindec_set,
   input  logic [3:0] minone_set,
   input  logic       set_en,
   input  logic       arm_btn,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic [3:0] hourdec_alm,
   output logic [3:0] hourone_alm,
   output logic [3:0] mindec_alm,
   output logic [3:0] minone_alm,
   output logic       armed,
   output logic       ringing,
   output logic       snoozing,
   output logic       buzzer
);

   typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

   localparam int unsigned RingW = $clog2(RING_TIMEOUT_SEC + 1);
   localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT_SEC - 1);

   state_e            state_q, state_d;
   logic [15:0]       alm_q, alm_d;
   logic [RingW-1:0]  ring_cnt_q, ring_cnt_d;
   logic              match, match_q;
   logic              set_ok;
   logic              armed_q, ringing_q, buzzer_q;

`ifdef ALARM_SNOOZE_EN
   localparam int unsigned SnzLoad = SNOOZE_MIN * 60;
   localparam int unsigned SnzW    = $clog2(SnzLoad + 1);
   logic [SnzW-1:0]   snz_cnt_q, snz_cnt_d;
   logic              snoozing_q;
   assign snoozing = snoozing_q;
`else
   logic              unused_snooze;
   assign unused_snooze = snooze_btn ^ (SNOOZE_MIN == 0);
   assign snoozing      = 1'b0;
`endif

   assign match = ({hourdec_now, hourone_now, mindec_now, minone_now} == alm_q);

   // Hour must be 00..23, minutes 00..59, every digit a legal BCD digit.
   assign set_ok = ((hourdec_set < 4'd2) || ((hourdec_set == 4'd2) && (hourone_set <= 4'd3)))
                   && (hourone_set <= 4'd9) && (mindec_set <= 4'd5) && (minone_set <= 4'd9);

   always_comb begin
      state_d    = state_q;
      alm_d      = alm_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
`endif
      if (set_en && set_ok && ((state_q == StIdle) || (state_q == StArmed))) begin
         alm_d = {hourdec_set, hourone_set, mindec_set, minone_set};
      end
      case (state_q)
         StIdle: begin
            if (arm_btn) state_d = StArmed;
         end
         StArmed: begin
            if (arm_btn) begin
               state_d = StIdle;
            end else if (match && !match_q) begin
               state_d    = StRinging;
               ring_cnt_d = '0;
            end
         end
         StRinging: begin
            if (stop_btn) begin
               state_d = StArmed;
            end else if (arm_btn) begin
               state_d = StIdle;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze_btn) begin
               state_d   = StSnooze;
               snz_cnt_d = SnzW'(SnzLoad);
`endif
            end else if (sec_tick) begin
               ring_cnt_d = ring_cnt_q + RingW'(1);
               if (ring_cnt_q == RingLast) state_d = StArmed;
            end
         end
`ifdef ALARM_SNOOZE_EN
         StSnooze: begin
            if (stop_btn) begin
               state_d = StArmed;
            end else if (arm_btn) begin
               state_d = StIdle;
            end else if (sec_tick) begin
               if (snz_cnt_q <= SnzW'(1)) begin
                  state_d    = StRinging;
                  snz_cnt_d  = '0;
                  ring_cnt_d = '0;
               end else begin
                  snz_cnt_d = snz_cnt_q - SnzW'(1);
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         alm_q      <= '0;
         ring_cnt_q <= '0;
         match_q    <= 1'b1;
         armed_q    <= 1'b0;
         ringing_q  <= 1'b0;
         buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_q  <= '0;
         snoozing_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         alm_q      <= alm_d;
         ring_cnt_q <= ring_cnt_d;
         match_q    <= match;
         armed_q    <= (state_d != StIdle);
         ringing_q  <= (state_d == StRinging);
         // Even ring seconds sound, odd ones are silent.
         buzzer_q   <= (state_d == StRinging) && !ring_cnt_d[0];
`ifdef ALARM_SNOOZE_EN
         snz_cnt_q  <= snz_cnt_d;
         snoozing_q <= (state_d == StSnooze);
`endif
      end
   end

   assign {hourdec_alm, hourone_alm, mindec_alm, minone_alm} = alm_q;
   assign armed   = armed_q;
   assign ringing = ringing_q;
   assign buzzer  = buzzer_q;

endmodule
